popcount_accumulator: RTL and testbench

POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

---
 rtl/popcount_accumulator.sv | 99 +++++++++
 tb/tb_popcount_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// Sums the set bits of every accepted beat over a frame, saturating at 2^COUNT_W-1 with a sticky overflow flag.
// The result is valid the cycle after the last beat; input is stalled (in_ready=0) until the result is taken.
module popcount_accumulator #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [COUNT_W-1:0] ACC_MAX = '1;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic               fa_sum, fa_carry, ha_carry;
  logic               sum_bit, carry_bit, cout_bit;
  logic [COUNT_W:0]   beat_val;
  logic [COUNT_W:0]   acc_sum;

  // 4-to-3 compressor: a full adder over bits 0..2, then bit 3 folded into the weight-1 and weight-2 columns.
  always_comb begin
    fa_sum    = in_data[0] ^ in_data[1] ^ in_data[2];
    fa_carry  = (in_data[0] & in_data[1]) | (in_data[0] & in_data[2]) | (in_data[1] & in_data[2]);
    ha_carry  = fa_sum & in_data[3];
    sum_bit   = fa_sum ^ in_data[3];
    carry_bit = fa_carry ^ ha_carry;
    cout_bit  = fa_carry & ha_carry;
  end

  assign beat_val = {{(COUNT_W-2){1'b0}}, cout_bit, carry_bit, sum_bit};
  assign acc_sum  = {1'b0, acc_q} + beat_val;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A single beat is at most 4, which always fits since COUNT_W >= 3.
          acc_d   = beat_val[COUNT_W-1:0];
          ovf_d   = 1'b0;
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (acc_sum[COUNT_W]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum[COUNT_W-1:0];
          end
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_count    = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Scoreboard bench: two instances (COUNT_W=8 and COUNT_W=4) driven by directed frames;
// a negedge monitor pops expected results on each output handshake and checks latency and stalls.
module tb_popcount_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_overflow;
  logic [3:0] a_in_data;
  logic [7:0] a_out_count;
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
  logic [3:0] b_in_data;
  logic [3:0] b_out_count;

  popcount_accumulator #(.COUNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count), .out_overflow(a_out_overflow)
  );

  popcount_accumulator #(.COUNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count), .out_overflow(b_out_overflow)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
  } res_t;

  res_t exp_a[$];
  res_t exp_b[$];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic       prev_vld [2] = '{1'b0, 1'b0};
  logic       prev_hs  [2] = '{1'b0, 1'b0};
  logic       prev_last[2] = '{1'b0, 1'b0};
  logic [7:0] prev_cnt [2] = '{8'd0, 8'd0};
  logic       prev_ovf [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic mon(input int id, input logic vld, input logic rdy, input logic in_rdy,
                     input logic in_vld, input logic in_lst, input logic [7:0] cnt, input logic ovf);
    res_t e;
    bit   empty;
    logic rising;
    rising = vld && !prev_vld[id];
    if (vld) check($sformatf("dut%0d_in_ready_while_done", id), in_rdy, 1'b0);
    if (prev_last[id] || rising)
      check($sformatf("dut%0d_valid_rise_after_last", id), rising, prev_last[id]);
    if (vld && prev_vld[id] && !prev_hs[id]) begin
      check($sformatf("dut%0d_count_stable", id), cnt, prev_cnt[id]);
      check($sformatf("dut%0d_overflow_stable", id), ovf, prev_ovf[id]);
    end
    if (vld && rdy) begin
      empty = (id == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_result: count %0d overflow %0d with nothing expected", id, cnt, ovf);
      end else begin
        e = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
        check($sformatf("dut%0d_out_count", id), cnt, e.cnt);
        check($sformatf("dut%0d_out_overflow", id), ovf, e.ovf);
      end
    end
    prev_vld[id]  = vld;
    prev_hs[id]   = vld && rdy;
    prev_last[id] = in_vld && in_rdy && in_lst && !rst;
    prev_cnt[id]  = cnt;
    prev_ovf[id]  = ovf;
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          prev_vld[i]  = 1'b0;
          prev_hs[i]   = 1'b0;
          prev_last[i] = 1'b0;
        end
      end else begin
        mon(0, a_out_valid, a_out_ready, a_in_ready, a_in_valid, a_in_last, a_out_count, a_out_overflow);
        mon(1, b_out_valid, b_out_ready, b_in_ready, b_in_valid, b_in_last, {4'b0, b_out_count}, b_out_overflow);
      end
    end
  end

  // Presents one beat and holds it until the DUT accepts it; leaves in_valid low afterwards.
  task automatic send(input int id, input logic [3:0] d, input logic l);
    int n = 0;
    if (id == 0) begin a_in_valid = 1'b1; a_in_data = d; a_in_last = l; end
    else         begin b_in_valid = 1'b1; b_in_data = d; b_in_last = l; end
    forever begin
      @(negedge clk);
      if (((id == 0) ? a_in_ready : b_in_ready) === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_send_timeout: in_ready stayed low for %0d cycles, required 1", id, n);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (id == 0) a_in_valid = 1'b0;
    else         b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: results pending a=%0d b=%0d, required 0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 4'h0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 4'h0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    @(negedge clk);
    check("reset_a_out_valid", a_out_valid, 1'b0);
    check("reset_a_out_count", a_out_count, 8'd0);
    check("reset_a_out_overflow", a_out_overflow, 1'b0);
    check("reset_a_in_ready", a_in_ready, 1'b1);
    check("reset_b_out_valid", b_out_valid, 1'b0);
    check("reset_b_in_ready", b_in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Three-beat frame, continuous valid: 4 + 2 + 1
    exp_a.push_back('{8'd7, 1'b0});
    send(0, 4'b1111, 1'b0);
    send(0, 4'b1010, 1'b0);
    send(0, 4'b0001, 1'b1);
    drain();
    check("after_frame_in_ready", a_in_ready, 1'b1);
    check("after_frame_count_cleared", a_out_count, 8'd0);

    // Single-beat frame from IDLE
    exp_a.push_back('{8'd3, 1'b0});
    send(0, 4'b0111, 1'b1);
    drain();

    // Result held back for 5 cycles while upstream keeps offering a last beat
    a_out_ready = 1'b0;
    exp_a.push_back('{8'd4, 1'b0});
    send(0, 4'b1100, 1'b0);
    send(0, 4'b0011, 1'b1);
    a_in_valid = 1'b1; a_in_data = 4'b1111; a_in_last = 1'b1;
    idle(5);
    check("held_out_valid", a_out_valid, 1'b1);
    check("held_out_count", a_out_count, 8'd4);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    drain();
    exp_a.push_back('{8'd1, 1'b0});
    send(0, 4'b0001, 1'b1);
    drain();

    // Reset in the middle of a frame discards it
    send(0, 4'b1111, 1'b0);
    send(0, 4'b1111, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset_out_count", a_out_count, 8'd0);
    check("mid_reset_out_valid", a_out_valid, 1'b0);
    exp_a.push_back('{8'd2, 1'b0});
    send(0, 4'b0011, 1'b1);
    drain();

    // Invalid cycles with ones on the data bus contribute nothing
    exp_a.push_back('{8'd3, 1'b0});
    send(0, 4'b0101, 1'b0);
    a_in_valid = 1'b0; a_in_data = 4'b1111; a_in_last = 1'b1;
    idle(3);
    send(0, 4'b1000, 1'b1);
    drain();

    // All-zero beats are accepted and count 0
    exp_a.push_back('{8'd0, 1'b0});
    send(0, 4'b0000, 1'b0);
    send(0, 4'b0000, 1'b1);
    drain();

    // 64 full beats total 256: saturate at 255 with overflow
    exp_a.push_back('{8'd255, 1'b1});
    for (int i = 0; i < 64; i++) send(0, 4'b1111, (i == 63));
    drain();

    // Narrow instance: 20 saturates to 15, next frame starts clean
    exp_b.push_back('{8'd15, 1'b1});
    for (int i = 0; i < 5; i++) send(1, 4'b1111, (i == 4));
    drain();
    exp_b.push_back('{8'd1, 1'b0});
    send(1, 4'b0001, 1'b1);
    drain();

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
